// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction fetch front end.
//   WORD_W           : datapath / address width
//   INSTR_BYTES      : bytes per instruction (fetch PC stride)
//   RESET_PC_DEFAULT : default fetch address after reset
//   NOP_INSTR        : encoding used for empty storage
//   fetch_entry_t    : one prefetch-queue entry {pc4, instr}
// ----------------------------------------------------------------------------
package mips_pkg;

    localparam int          WORD_W           = 32;
    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc4;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    // Sequential fetch address; wraps naturally modulo 2^32.
    function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc);
        return pc + WORD_W'(INSTR_BYTES);
    endfunction

    // Force a fetch target onto an instruction boundary.
    function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] pc);
        return pc & ~WORD_W'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch_entry_t with flush. Storage, pointers and count
// are all reset asynchronously (active low) so the head reads as zero after
// reset.
//   clk      in   clock (rising edge)
//   rst_n    in   asynchronous active-low reset
//   i_flush  in   empty the queue (pointers and count to zero); wins over
//                 push/pop
//   i_push   in   write i_wdata at the write pointer
//   i_pop    in   advance the read pointer
//   i_wdata  in   entry to write
//   o_rdata  out  entry at the read pointer (combinational from flops)
//   o_count  out  occupied entries
//   o_empty  out  count == 0
//   o_full   out  count == DEPTH
// ----------------------------------------------------------------------------
module fetch_fifo
    import mips_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_flush,
    input  logic               i_push,
    input  logic               i_pop,
    input  fetch_entry_t       i_wdata,
    output fetch_entry_t       o_rdata,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_empty,
    output logic               o_full
);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    fetch_entry_t     w_mem [DEPTH];
    logic             w_wr_en;
    logic             w_rd_en;

    assign w_wr_en = i_push & ~i_flush;
    assign w_rd_en = i_pop  & ~i_flush;

    // One register per entry; each loads only when the write pointer
    // selects it.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_entry_t r_entry;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_entry <= '{pc4: '0, instr: NOP_INSTR};
                end else if (w_wr_en && (r_wr_ptr == PTR_W'(gi))) begin
                    r_entry <= i_wdata;
                end
            end

            assign w_mem[gi] = r_entry;
        end
    endgenerate

    // Pointers wrap modulo DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = w_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
// Instruction fetch stage with a prefetch queue. Owns the fetch PC, reads the
// combinational instruction memory each cycle and queues {PC+4, instr} for
// decode. A redirect flushes the queue and reloads the PC.
//   clk          in   clock (rising edge)
//   rst_n        in   asynchronous active-low reset
//   redirect     in   branch/jump taken; flushes queue, reloads PC
//   redirect_pc  in   new fetch address (low two bits ignored)
//   imem_addr    out  fetch address (= fetch PC)
//   imem_data    in   instruction at imem_addr, same cycle
//   dec_valid    out  queue head is valid
//   dec_ready    in   decode accepts the head this cycle
//   dec_instr    out  head instruction
//   dec_pc4      out  head instruction address + 4
//   count        out  occupied entries
// ----------------------------------------------------------------------------
module fetch_queue
    import mips_pkg::*;
#(
    parameter  int          DEPTH    = 4,
    parameter  logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    localparam int          CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect,
    input  logic [WORD_W-1:0]  redirect_pc,
    output logic [WORD_W-1:0]  imem_addr,
    input  logic [WORD_W-1:0]  imem_data,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [WORD_W-1:0]  dec_instr,
    output logic [WORD_W-1:0]  dec_pc4,
    output logic [CNT_W-1:0]   count
);

    logic [WORD_W-1:0] r_fetch_pc;
    logic [WORD_W-1:0] w_pc4;
    logic              w_pop;
    logic              w_push;
    logic              w_empty;
    logic              w_full;
    fetch_entry_t      w_wdata;
    fetch_entry_t      w_head;

    assign w_pc4 = next_pc(r_fetch_pc);

    // A handshake coinciding with a redirect is dropped: the head belongs to
    // the flushed path.
    assign w_pop  = dec_valid & dec_ready & ~redirect;
    // When full, a slot frees up only if the head leaves this same cycle.
    assign w_push = ~redirect & (~w_full | w_pop);

    assign w_wdata = '{pc4: w_pc4, instr: imem_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect) begin
            r_fetch_pc <= align_pc(redirect_pc);
        end else if (w_push) begin
            r_fetch_pc <= w_pc4;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (redirect),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_count (count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign imem_addr = r_fetch_pc;
    assign dec_valid = ~w_empty;
    assign dec_instr = w_head.instr;
    assign dec_pc4   = w_head.pc4;

endmodule

// File: tb/tb_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_queue
// Directed stimulus for fetch_queue. Instance u_dut uses RESET_PC = 0;
// u_dut_wrap uses RESET_PC = 32'hFFFF_FFF8. Memory word k holds
// 32'h1000_0000 + k. Expected fetch streams are queued by the stimulus and
// consumed by monitors on every accepted handshake.
// ----------------------------------------------------------------------------
module tb_fetch_queue;
    import mips_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 1
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc4;
    logic [2:0]  count;

    // Instance 2 (wrap-around reset PC)
    logic        rst2_n;
    logic        redirect2;
    logic [31:0] redirect_pc2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_data2;
    logic        dec_valid2;
    logic        dec_ready2;
    logic [31:0] dec_instr2;
    logic [31:0] dec_pc4_2;
    logic [2:0]  count2;

    int n_checks = 0;
    int n_errors = 0;

    fetch_entry_t exp_q[$];
    fetch_entry_t exp_q2[$];

    assign imem_data  = 32'h1000_0000 + (imem_addr  >> 2);
    assign imem_data2 = 32'h1000_0000 + (imem_addr2 >> 2);

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .dec_pc4     (dec_pc4),
        .count       (count)
    );

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'hFFFF_FFF8)
    ) u_dut_wrap (
        .clk         (clk),
        .rst_n       (rst2_n),
        .redirect    (redirect2),
        .redirect_pc (redirect_pc2),
        .imem_addr   (imem_addr2),
        .imem_data   (imem_data2),
        .dec_valid   (dec_valid2),
        .dec_ready   (dec_ready2),
        .dec_instr   (dec_instr2),
        .dec_pc4     (dec_pc4_2),
        .count       (count2)
    );

    function automatic fetch_entry_t mk(input logic [31:0] pc);
        fetch_entry_t e;
        e.pc4   = pc + 32'd4;
        e.instr = 32'h1000_0000 + (pc >> 2);
        return e;
    endfunction

    // Expected consumption order from a fresh fetch start address.
    task automatic preload(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(mk(pc + 32'(4 * i)));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Monitor for instance 1: inputs are driven at the falling edge, so
    // sampling 2 units later sees the handshake that the next rising edge
    // will take.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && dec_valid && dec_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_empty: got pc4 %h expected no entry", dec_pc4);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc4", dec_pc4, e.pc4);
                    check("pop_instr", dec_instr, e.instr);
                    $display("t=%0t dut pop pc4=%h instr=%h", $time, dec_pc4, dec_instr);
                end
            end
        end
    end

    // Monitor for instance 2.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst2_n === 1'b1 && dec_valid2 && dec_ready2 && !redirect2) begin
                if (exp_q2.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb2_empty: got pc4 %h expected no entry", dec_pc4_2);
                end else begin
                    e = exp_q2.pop_front();
                    check("pop2_pc4", dec_pc4_2, e.pc4);
                    check("pop2_instr", dec_instr2, e.instr);
                    $display("t=%0t wrap pop pc4=%h instr=%h", $time, dec_pc4_2, dec_instr2);
                end
            end
        end
    end

    initial begin
        int c;
        rst_n        = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        dec_ready    = 1'b0;
        rst2_n       = 1'b0;
        redirect2    = 1'b0;
        redirect_pc2 = 32'h0;
        dec_ready2   = 1'b1;
        preload(32'h0);
        exp_q2.delete();
        for (int i = 0; i < 16; i++) exp_q2.push_back(mk(32'hFFFF_FFF8 + 32'(4 * i)));

        // Reset state
        repeat (2) step();
        check("rst_valid", 32'(dec_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_instr", dec_instr, 32'h0);
        check("rst_pc4", dec_pc4, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst2_imem_addr", imem_addr2, 32'hFFFF_FFF8);
        check("rst2_valid", 32'(dec_valid2), 32'd0);
        rst_n = 1'b1;

        // Backpressure: fill in 4 cycles, then fetch stalls with a stable head
        for (int k = 1; k <= 10; k++) begin
            step();
            c = (k < 4) ? k : 4;
            check("bp_count", 32'(count), 32'(c));
            check("bp_imem_addr", imem_addr, 32'(4 * c));
            check("bp_valid", 32'(dec_valid), 32'd1);
            check("bp_head_pc4", dec_pc4, 32'd4);
            check("bp_head_instr", dec_instr, 32'h1000_0000);
        end

        // Drain: full queue pushes and pops together
        dec_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("drain_count", 32'(count), 32'd4);
        end

        // Redirect, then refill to count = 3
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        dec_ready   = 1'b0;
        preload(32'h200);
        step();
        check("redir1_count", 32'(count), 32'd0);
        check("redir1_imem_addr", imem_addr, 32'h200);
        redirect = 1'b0;
        repeat (3) step();
        check("fill3_count", 32'(count), 32'd3);

        // Redirect at count = 3 to an unaligned target
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        preload(32'h100);
        step();
        check("redir2_count", 32'(count), 32'd0);
        check("redir2_valid", 32'(dec_valid), 32'd0);
        check("redir2_imem_addr", imem_addr, 32'h100);
        redirect = 1'b0;
        step();
        check("redir2_next_count", 32'(count), 32'd1);
        check("redir2_next_valid", 32'(dec_valid), 32'd1);
        check("redir2_next_pc4", dec_pc4, 32'h104);
        check("redir2_next_instr", dec_instr, 32'h1000_0040);

        // Redirect with a same-cycle handshake while full
        repeat (3) step();
        check("full_count", 32'(count), 32'd4);
        dec_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        preload(32'h40);
        step();
        check("redir3_count", 32'(count), 32'd0);
        check("redir3_valid", 32'(dec_valid), 32'd0);
        check("redir3_imem_addr", imem_addr, 32'h40);
        redirect = 1'b0;
        step();
        check("redir3_next_count", 32'(count), 32'd1);
        check("redir3_next_pc4", dec_pc4, 32'h44);

        // Free-run at one instruction per cycle
        for (int k = 0; k < 6; k++) begin
            step();
            check("run_count", 32'(count), 32'd1);
        end

        // Asynchronous reset pulse mid-fill
        dec_ready = 1'b0;
        repeat (2) step();
        check("midfill_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        preload(32'h0);
        #1;
        check("arst_valid", 32'(dec_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_imem_addr", imem_addr, 32'h0);
        check("arst_pc4", dec_pc4, 32'h0);
        check("arst_instr", dec_instr, 32'h0);
        #3;
        rst_n     = 1'b1;
        dec_ready = 1'b1;
        step();
        check("resume_count", 32'(count), 32'd1);
        check("resume_pc4", dec_pc4, 32'd4);
        check("resume_imem_addr", imem_addr, 32'd4);
        repeat (4) step();

        // Wrap-around of the fetch PC
        rst2_n = 1'b1;
        step();
        check("wrap_imem_addr_1", imem_addr2, 32'hFFFF_FFFC);
        check("wrap_pc4_1", dec_pc4_2, 32'hFFFF_FFFC);
        step();
        check("wrap_imem_addr_2", imem_addr2, 32'h0000_0000);
        check("wrap_pc4_2", dec_pc4_2, 32'h0000_0000);
        step();
        check("wrap_imem_addr_3", imem_addr2, 32'h0000_0004);
        check("wrap_pc4_3", dec_pc4_2, 32'h0000_0004);
        check("wrap_count", 32'(count2), 32'd1);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
